// File: rtl/store_format_unit.sv
// Store formatting unit: aligns and lane-replicates store data, drives a single
// outstanding memory write, and reports address-error and bus-timeout exceptions.
module store_format_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic [31:0] exc_badvaddr
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StFault} state_e;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        exc_ades_q, exc_ades_d;
  logic        exc_bus_q, exc_bus_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        misaligned;
  logic        cnt_expired;

  always_comb begin
    misaligned = 1'b0;
    unique case (in_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = (in_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Ack on the expiring edge is handled first, so it wins over the timeout.
  assign cnt_expired = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    exc_ades_d  = 1'b0;
    exc_bus_d   = 1'b0;
    badvaddr_d  = badvaddr_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          addr_d = in_addr;
          if (misaligned) begin
            state_d    = StFault;
            exc_ades_d = 1'b1;
            badvaddr_d = in_addr;
          end else begin
            state_d    = StIssue;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {in_addr[31:2], 2'b00};
            unique case (in_size)
              2'b00: begin
                mem_wdata_d = {4{in_data[7:0]}};
                mem_be_d    = 4'b0001 << in_addr[1:0];
              end
              2'b01: begin
                mem_wdata_d = {2{in_data[15:0]}};
                mem_be_d    = in_addr[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                mem_wdata_d = in_data;
                mem_be_d    = 4'b1111;
              end
            endcase
          end
        end
      end
      StIssue: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
        end else if (cnt_expired) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          exc_bus_d  = 1'b1;
          badvaddr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFault: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      exc_ades_q  <= 1'b0;
      exc_bus_q   <= 1'b0;
      badvaddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      exc_ades_q  <= exc_ades_d;
      exc_bus_q   <= exc_bus_d;
      badvaddr_q  <= badvaddr_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign exc_ades     = exc_ades_q;
  assign exc_bus      = exc_bus_q;
  assign exc_badvaddr = badvaddr_q;

endmodule

// File: tb/tb_store_format_unit.sv
// Bench for store_format_unit: vector table plus scoreboard monitor, with
// hand-written timeout, reset-abort and back-to-back sequences.
module tb_store_format_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        exc_ades;
  logic        exc_bus;
  logic [31:0] exc_badvaddr;

  always #5 clk = ~clk;

  store_format_unit #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_size      (in_size),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .exc_ades     (exc_ades),
    .exc_bus      (exc_bus),
    .exc_badvaddr (exc_badvaddr)
  );

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_dly;
    logic        fault;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb_q[$];
  vec_t cur;
  vec_t vecs[9];
  logic req_prev = 1'b0;
  logic mon_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expectation per new mem_req or exc_ades pulse.
  always @(negedge clk) begin
    if (mon_on) begin
      check("exc_exclusive", {31'b0, exc_ades & exc_bus}, 32'h0);
      if (mem_req && !req_prev) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow_req", 32'h1, 32'h0);
        end else begin
          cur = sb_q.pop_front();
          check("req_not_fault", {31'b0, cur.fault}, 32'h0);
          check("mem_addr", mem_addr, cur.e_addr);
          check("mem_wdata", mem_wdata, cur.e_wdata);
          check("mem_be", {28'b0, mem_be}, {28'b0, cur.e_be});
        end
      end else if (mem_req) begin
        check("hold_addr", mem_addr, cur.e_addr);
        check("hold_wdata", mem_wdata, cur.e_wdata);
        check("hold_be", {28'b0, mem_be}, {28'b0, cur.e_be});
      end
      if (exc_ades) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow_ades", 32'h1, 32'h0);
        end else begin
          cur = sb_q.pop_front();
          check("ades_expected", {31'b0, cur.fault}, 32'h1);
          check("ades_badvaddr", exc_badvaddr, cur.e_addr);
        end
      end
    end
    req_prev = mem_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_size  = v.size;
    in_addr  = v.addr;
    in_data  = v.data;
    sb_q.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    tick();
    in_valid = 1'b0;
    if (v.fault) begin
      @(negedge clk);
      check("fault_in_ready", {31'b0, in_ready}, 32'h0);
      check("fault_ades", {31'b0, exc_ades}, 32'h1);
      check("fault_no_req", {31'b0, mem_req}, 32'h0);
      tick();
      @(negedge clk);
      check("fault_done_ready", {31'b0, in_ready}, 32'h1);
      check("fault_ades_pulse", {31'b0, exc_ades}, 32'h0);
      check("fault_done_no_req", {31'b0, mem_req}, 32'h0);
      tick();
    end else begin
      repeat (v.ack_dly) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      check("ack_req_drop", {31'b0, mem_req}, 32'h0);
      check("ack_in_ready", {31'b0, in_ready}, 32'h1);
      check("ack_no_bus", {31'b0, exc_bus}, 32'h0);
      tick();
    end
  endtask

  initial begin
    vec_t tv;
    int   cnt;
    logic bad;

    vecs[0] = '{2'b00, 32'h0000_1003, 32'hAABB_CCDD, 0, 1'b0, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000};
    vecs[1] = '{2'b01, 32'h0000_2002, 32'h1234_5678, 0, 1'b0, 32'h0000_2000, 32'h5678_5678, 4'b1100};
    vecs[2] = '{2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111};
    vecs[3] = '{2'b00, 32'h0000_0010, 32'h0000_0011, 1, 1'b0, 32'h0000_0010, 32'h1111_1111, 4'b0001};
    vecs[4] = '{2'b01, 32'h0000_5000, 32'hCAFE_BABE, 2, 1'b0, 32'h0000_5000, 32'hBABE_BABE, 4'b0011};
    vecs[5] = '{2'b10, 32'h0000_4002, 32'h0000_0000, 0, 1'b1, 32'h0000_4002, 32'h0, 4'b0000};
    vecs[6] = '{2'b11, 32'h0000_6000, 32'h0000_0000, 0, 1'b1, 32'h0000_6000, 32'h0, 4'b0000};
    vecs[7] = '{2'b01, 32'h0000_7001, 32'h0000_0000, 0, 1'b1, 32'h0000_7001, 32'h0, 4'b0000};
    vecs[8] = '{2'b00, 32'h0000_8001, 32'h0000_005A, 3, 1'b0, 32'h0000_8000, 32'h5A5A_5A5A, 4'b0010};

    // Reset with a valid request pending: it must not be accepted.
    rst_n    = 1'b0;
    mem_ack  = 1'b0;
    in_valid = 1'b1;
    in_size  = 2'b10;
    in_addr  = 32'h0000_0100;
    in_data  = 32'h1234_0000;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_be", {28'b0, mem_be}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_exc_ades", {31'b0, exc_ades}, 32'h0);
    check("rst_exc_bus", {31'b0, exc_bus}, 32'h0);
    check("rst_badvaddr", exc_badvaddr, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    mon_on = 1'b1;
    tick();
    @(negedge clk);
    check("rst_no_accept", {31'b0, mem_req}, 32'h0);
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Timeout: no ack, mem_req held for TO cycles then exc_bus pulse.
    tv = '{2'b10, 32'h0000_9000, 32'h0102_0304, 0, 1'b0, 32'h0000_9000, 32'h0102_0304, 4'b1111};
    drive(tv);
    tick();
    in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      cnt++;
    end
    check("to_req_cycles", cnt, TO);
    check("to_exc_bus", {31'b0, exc_bus}, 32'h1);
    check("to_badvaddr", exc_badvaddr, 32'h0000_9000);
    check("to_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    check("to_bus_pulse", {31'b0, exc_bus}, 32'h0);
    tick();

    // Ack on the expiring cycle wins over the timeout.
    tv = '{2'b10, 32'h0000_9100, 32'h0A0B_0C0D, 0, 1'b0, 32'h0000_9100, 32'h0A0B_0C0D, 4'b1111};
    drive(tv);
    tick();
    in_valid = 1'b0;
    repeat (TO - 1) tick();
    check("late_ack_req_high", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req_drop", {31'b0, mem_req}, 32'h0);
    check("late_ack_no_bus", {31'b0, exc_bus}, 32'h0);
    @(negedge clk);
    check("late_ack_no_bus2", {31'b0, exc_bus}, 32'h0);
    tick();

    // Reset while in ISSUE aborts silently.
    tv = '{2'b10, 32'h0000_A004, 32'h5555_AAAA, 0, 1'b0, 32'h0000_A004, 32'h5555_AAAA, 4'b1111};
    drive(tv);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_drop", {31'b0, mem_req}, 32'h0);
    check("abort_in_ready", {31'b0, in_ready}, 32'h1);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_req || exc_bus || exc_ades) bad = 1'b1;
    end
    check("abort_quiet", {31'b0, bad}, 32'h0);
    tick();
    run_vec(vecs[0]);

    // Back-to-back with in_valid held and ack tied high.
    mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(vecs[(k == 4) ? 8 : k]);
      tick();
      check("b2b_busy", {31'b0, in_ready}, 32'h0);
      tick();
      check("b2b_ready", {31'b0, in_ready}, 32'h1);
    end
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    repeat (3) tick();

    check("sb_empty", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_format_unit.md
STORE_FORMAT_UNIT -- requirements
Module: store_format_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, number of mem_ack wait cycles before bus error (0 = never time out).
REQ-002 SHALL have ports, one per line (name direction width meaning):
  clk  input  1  single clock, all state updates on rising edge
  rst_n  input  1  reset, synchronous, active-low
  in_valid  input  1  store request valid
  in_ready  output  1  unit can accept a store request
  in_addr  input  32  byte address of store
  in_data  input  32  register value to store (rt)
  in_size  input  2  00 byte (SB), 01 halfword (SH), 10 word (SW), 11 reserved
  mem_req  output  1  memory write request
  mem_addr  output  32  word-aligned memory address
  mem_wdata  output  32  lane-replicated write data
  mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
  mem_ack  input  1  memory accepted the write
  exc_ades  output  1  address-error-on-store pulse
  exc_bus  output  1  bus-timeout pulse
  exc_badvaddr  output  32  faulting address, valid with exc_ades or exc_bus
REQ-003 Reset SHALL be synchronous and active-low on rst_n; one clock domain, clk.

Function
REQ-004 SHALL implement states IDLE, ISSUE, FAULT.
REQ-005 in_ready SHALL equal 1 only in IDLE (combinational from state).
REQ-006 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; in_addr/in_data/in_size captured then.
REQ-007 Misalignment SHALL be: size 01 with addr[0]=1; size 10 with addr[1:0]!=00; size 11 always.
REQ-008 Accepted misaligned request: IDLE->FAULT; no mem_req ever asserted for it.
REQ-009 In FAULT (exactly one cycle): exc_ades=1, exc_badvaddr=captured addr; next state IDLE.
REQ-010 Accepted aligned request: IDLE->ISSUE; mem_req=1 from the cycle after acceptance (latency 1).
REQ-011 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-012 Byte: mem_wdata={4{data[7:0]}}, mem_be=4'b0001<<addr[1:0].
REQ-013 Halfword: mem_wdata={2{data[15:0]}}, mem_be=addr[1]?4'b1100:4'b0011.
REQ-014 Word: mem_wdata=data, mem_be=4'b1111.
REQ-015 mem_addr/mem_wdata/mem_be SHALL be registered and held stable while mem_req=1.
REQ-016 ISSUE->IDLE on edge with mem_ack=1; mem_req deasserts next cycle; ack on the first ISSUE cycle completes in one cycle.
REQ-017 mem_ack while mem_req=0 SHALL be ignored.
REQ-018 Wait counter SHALL clear on entering ISSUE and increment each ISSUE cycle without mem_ack.
REQ-019 TIMEOUT!=0 and counter reaches TIMEOUT without ack: ISSUE->IDLE, mem_req drops, exc_bus=1 for one cycle, exc_badvaddr=captured addr.
REQ-020 mem_ack on the same edge the counter reaches TIMEOUT SHALL win: normal completion, no exc_bus.
REQ-021 exc_ades and exc_bus SHALL never be asserted together; both are one-cycle pulses.
REQ-022 Maximum throughput: one store per two cycles (accept, ack in ISSUE, back in IDLE).

Reset
REQ-023 On rising edge with rst_n=0: state=IDLE, counter=0, mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, exc_ades=0, exc_bus=0, exc_badvaddr=0.
REQ-024 Reset during ISSUE or FAULT SHALL abort the operation: no exception pulse, no further mem_req; in_ready=1 the cycle after rst_n returns high.
REQ-025 in_valid while rst_n=0 SHALL not be accepted.

Verification
REQ-026 SB addr=0x0000_1003, data=0xAABB_CCDD -> next cycle mem_req=1, mem_addr=0x0000_1000, mem_wdata=0xDDDD_DDDD, mem_be=1000; ack -> mem_req=0 following cycle.
REQ-027 SH addr=0x0000_2002, data=0x1234_5678 -> mem_wdata=0x5678_5678, mem_be=1100; SW addr=0x0000_3000, data=0xDEAD_BEEF -> mem_be=1111, mem_wdata=0xDEAD_BEEF.
REQ-028 SW addr=0x0000_4002 -> no mem_req, exc_ades=1 for one cycle with exc_badvaddr=0x0000_4002; in_size=11 likewise.
REQ-029 TIMEOUT=4, SW with mem_ack held 0 -> mem_req high exactly 4 cycles, then exc_bus one-cycle pulse, in_ready=1 after; repeat with ack on 4th cycle -> no exc_bus.
REQ-030 rst_n=0 for one edge while in ISSUE -> mem_req=0 next cycle, no exception, new request accepted normally afterward.
REQ-031 Back-to-back stores with in_valid held and mem_ack tied 1 -> accepts every second cycle, each mem_be/mem_wdata matching its own request.
